// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the R-type issue slice.
//   REG_ADDR_W      register address width
//   OPCODE_RTYPE    opcode field value of R-type instructions
//   FUNCT_*         supported funct codes (add/addu/sub/subu)
//   state_t         issue FSM state encoding
//   is_legal/is_sub decode helpers
package cpu_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
  localparam logic [5:0] FUNCT_ADD    = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU   = 6'b100001;
  localparam logic [5:0] FUNCT_SUB    = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU   = 6'b100011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_EXEC  = 2'b10,
    ST_WRITE = 2'b11
  } state_t;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
    return (op == OPCODE_RTYPE) &&
           ((funct == FUNCT_ADD) || (funct == FUNCT_ADDU) ||
            (funct == FUNCT_SUB) || (funct == FUNCT_SUBU));
  endfunction

  function automatic logic is_sub(input logic [5:0] funct);
    return (funct == FUNCT_SUB) || (funct == FUNCT_SUBU);
  endfunction

endpackage

// File: rtl/reg_file.sv
// reg_file: NREGS x WIDTH register file, R0 hardwired to zero.
//   clk, rst             clock, asynchronous active-high reset (clears all)
//   i_we/i_waddr/i_wdata single synchronous write port
//   i_raddr_a/o_rdata_a  asynchronous read port A
//   i_raddr_b/o_rdata_b  asynchronous read port B
//   i_raddr_d/o_rdata_d  asynchronous debug read port
module reg_file
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic [REG_ADDR_W-1:0] i_raddr_a,
  input  logic [REG_ADDR_W-1:0] i_raddr_b,
  input  logic [REG_ADDR_W-1:0] i_raddr_d,
  output logic [WIDTH-1:0]      o_rdata_a,
  output logic [WIDTH-1:0]      o_rdata_b,
  output logic [WIDTH-1:0]      o_rdata_d
);

  logic [WIDTH-1:0] r_mem [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_mem[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_mem[i_raddr_b];
  assign o_rdata_d = (i_raddr_d == '0) ? '0 : r_mem[i_raddr_d];

endmodule

// File: rtl/rtype_issue.sv
// rtype_issue: issue/writeback stage feeding an external multi-cycle adder.
//   clk, rst                    clock, asynchronous active-high reset
//   instr_valid/instr           instruction offer; accepted only when instr_ready
//   instr_ready                 high in IDLE
//   add_x/add_y                 registered adder operands (add_y negated for sub)
//   add_out                     adder result, captured into R[rd] at end of WRITE
//   done                        one-cycle pulse in WRITE
//   err                         one-cycle pulse on illegal op/funct
//   busy                        not IDLE
//   dbg_we/dbg_waddr/dbg_wdata  register load, honoured only in IDLE
//   dbg_raddr/dbg_rdata         combinational register peek
module rtype_issue
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned WAIT_CONST = 0,
  parameter int unsigned NREGS      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic [31:0]           instr,
  output logic                  instr_ready,
  output logic [WIDTH-1:0]      add_x,
  output logic [WIDTH-1:0]      add_y,
  input  logic [WIDTH-1:0]      add_out,
  output logic                  done,
  output logic                  err,
  output logic                  busy,
  input  logic                  dbg_we,
  input  logic [REG_ADDR_W-1:0] dbg_waddr,
  input  logic [WIDTH-1:0]      dbg_wdata,
  input  logic [REG_ADDR_W-1:0] dbg_raddr,
  output logic [WIDTH-1:0]      dbg_rdata
);

  localparam logic [1:0]       LP_WAIT_LAST = 2'(WAIT_CONST);
  localparam logic [WIDTH-1:0] LP_ONE       = WIDTH'(1);

  state_t                r_state;
  state_t                w_next;
  logic [REG_ADDR_W-1:0] r_rs, r_rt, r_rd;
  logic [5:0]            r_op, r_funct;
  logic [1:0]            r_cnt;
  logic [WIDTH-1:0]      r_add_x, r_add_y;

  logic                  w_accept, w_legal, w_sub;
  logic [WIDTH-1:0]      w_rs_data, w_rt_data;
  logic                  w_rf_we;
  logic [REG_ADDR_W-1:0] w_rf_waddr;
  logic [WIDTH-1:0]      w_rf_wdata;
  logic                  w_unused_sh;

  assign w_unused_sh = ^instr[10:6];
  assign w_accept    = instr_valid && (r_state == ST_IDLE);
  assign w_legal     = is_legal(r_op, r_funct);
  assign w_sub       = is_sub(r_funct);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (instr_valid)            w_next = ST_READ;
      ST_READ:  w_next = w_legal ? ST_EXEC : ST_IDLE;
      ST_EXEC:  if (r_cnt == LP_WAIT_LAST)  w_next = ST_WRITE;
      ST_WRITE: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    instr_ready = (r_state == ST_IDLE);
    busy        = (r_state != ST_IDLE);
    done        = (r_state == ST_WRITE);
    err         = (r_state == ST_READ) && !w_legal;
  end

  // Field latch, operand registers and EXEC hold counter. The counter runs
  // 0..WAIT_CONST so the operands stay stable for WAIT_CONST+1 cycles, which
  // guarantees the adder's free-running sampler sees them at least once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_op    <= '0;
      r_funct <= '0;
      r_cnt   <= '0;
      r_add_x <= '0;
      r_add_y <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= instr[31:26];
        r_rs    <= instr[25:21];
        r_rt    <= instr[20:16];
        r_rd    <= instr[15:11];
        r_funct <= instr[5:0];
      end
      if ((r_state == ST_READ) && w_legal) begin
        r_add_x <= w_rs_data;
        r_add_y <= w_sub ? (~w_rt_data + LP_ONE) : w_rt_data;
      end
      if (r_state == ST_READ)      r_cnt <= '0;
      else if (r_state == ST_EXEC) r_cnt <= r_cnt + 2'd1;
    end
  end

  assign add_x = r_add_x;
  assign add_y = r_add_y;

  // Writeback and debug load share one port; they cannot collide because
  // debug loads are only honoured in IDLE.
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = dbg_waddr;
    w_rf_wdata = dbg_wdata;
    if (r_state == ST_WRITE) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = r_rd;
      w_rf_wdata = add_out;
    end else if ((r_state == ST_IDLE) && dbg_we) begin
      w_rf_we    = 1'b1;
    end
  end

  reg_file #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_rf_we),
    .i_waddr   (w_rf_waddr),
    .i_wdata   (w_rf_wdata),
    .i_raddr_a (r_rs),
    .i_raddr_b (r_rt),
    .i_raddr_d (dbg_raddr),
    .o_rdata_a (w_rs_data),
    .o_rdata_b (w_rt_data),
    .o_rdata_d (dbg_rdata)
  );

endmodule

// File: tb/tb_rtype_issue.sv
`timescale 1ns/1ps
// tb_rtype_issue: two instances (WAIT_CONST=0 and 3), each beside a small
// free-running adder, compared every cycle against a transaction-level model.
module tb_rtype_issue;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        iv   [2];
  logic [31:0] ins  [2];
  logic        rdy  [2];
  logic [31:0] ax   [2];
  logic [31:0] ay   [2];
  logic [31:0] aout [2];
  logic        dn   [2];
  logic        er   [2];
  logic        bz   [2];
  logic        dwe  [2];
  logic [4:0]  dwa  [2];
  logic [31:0] dwd  [2];
  logic [4:0]  dra  [2];
  logic [31:0] drd  [2];

  rtype_issue #(.WIDTH(32), .WAIT_CONST(0), .NREGS(32)) u_dut0 (
    .clk(clk), .rst(rst), .instr_valid(iv[0]), .instr(ins[0]), .instr_ready(rdy[0]),
    .add_x(ax[0]), .add_y(ay[0]), .add_out(aout[0]), .done(dn[0]), .err(er[0]),
    .busy(bz[0]), .dbg_we(dwe[0]), .dbg_waddr(dwa[0]), .dbg_wdata(dwd[0]),
    .dbg_raddr(dra[0]), .dbg_rdata(drd[0]));

  rtype_issue #(.WIDTH(32), .WAIT_CONST(3), .NREGS(32)) u_dut3 (
    .clk(clk), .rst(rst), .instr_valid(iv[1]), .instr(ins[1]), .instr_ready(rdy[1]),
    .add_x(ax[1]), .add_y(ay[1]), .add_out(aout[1]), .done(dn[1]), .err(er[1]),
    .busy(bz[1]), .dbg_we(dwe[1]), .dbg_waddr(dwa[1]), .dbg_wdata(dwd[1]),
    .dbg_raddr(dra[1]), .dbg_rdata(drd[1]));

  function automatic int wc(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Adder: free-running sampler with period WAIT_CONST+1.
  int aclk_cnt [2] = '{0, 0};
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (aclk_cnt[d] == wc(d)) begin
        aclk_cnt[d] <= 0;
        aout[d]     <= ax[d] + ay[d];
      end else begin
        aclk_cnt[d] <= aclk_cnt[d] + 1;
      end
    end
  end

  // Counters
  int checks   = 0;
  int failures = 0;

  task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Transaction-level model. m_age = whole cycles elapsed since the accept edge.
  logic [31:0] m_reg [2][32];
  bit          m_act [2];
  bit          m_ill [2];
  int          m_age [2];
  logic [4:0]  m_rd  [2];
  logic [31:0] m_opx [2];
  logic [31:0] m_opy [2];
  logic [31:0] m_x   [2];
  logic [31:0] m_y   [2];

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) m_reg[d][i] = 32'd0;
      m_act[d] = 1'b0; m_ill[d] = 1'b0; m_age[d] = 0; m_rd[d] = 5'd0;
      m_opx[d] = 32'd0; m_opy[d] = 32'd0; m_x[d] = 32'd0; m_y[d] = 32'd0;
    end
  endtask

  task automatic model_step();
    logic [5:0] op, fn;
    logic [31:0] a, b;
    for (int d = 0; d < 2; d++) begin
      if (m_act[d]) begin
        if (m_age[d] == 0) begin
          if (m_ill[d]) m_act[d] = 1'b0;
          else begin m_x[d] = m_opx[d]; m_y[d] = m_opy[d]; end
        end else if (m_age[d] == wc(d) + 2) begin
          if (m_rd[d] != 5'd0) m_reg[d][m_rd[d]] = m_opx[d] + m_opy[d];
          m_act[d] = 1'b0;
        end
        m_age[d]++;
      end else begin
        if (dwe[d] && dwa[d] != 5'd0) m_reg[d][dwa[d]] = dwd[d];
        if (iv[d]) begin
          op = ins[d][31:26];
          fn = ins[d][5:0];
          a  = m_reg[d][ins[d][25:21]];
          b  = m_reg[d][ins[d][20:16]];
          m_ill[d] = !(op == 6'd0 && (fn == 6'h20 || fn == 6'h21 || fn == 6'h22 || fn == 6'h23));
          m_opx[d] = a;
          m_opy[d] = (fn == 6'h22 || fn == 6'h23) ? (32'd0 - b) : b;
          m_rd[d]  = ins[d][15:11];
          m_act[d] = 1'b1;
          m_age[d] = 0;
        end
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_clear();
      else     model_step();
    end
  end

  // Per-cycle compare against the model
  bit cmp_en = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int d = 0; d < 2; d++) begin
          chk(d, "ready", 32'(rdy[d]), 32'(!m_act[d]));
          chk(d, "busy",  32'(bz[d]),  32'(m_act[d]));
          chk(d, "done",  32'(dn[d]),  32'(m_act[d] && !m_ill[d] && m_age[d] == wc(d) + 2));
          chk(d, "err",   32'(er[d]),  32'(m_act[d] && m_ill[d] && m_age[d] == 0));
          chk(d, "add_x", ax[d], m_x[d]);
          chk(d, "add_y", ay[d], m_y[d]);
          chk(d, "dbg_rdata", drd[d], m_reg[d][dra[d]]);
        end
      end
    end
  end

  // Stimulus helpers
  task automatic step();
    @(posedge clk); #2;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn,
                                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic dbg_load(input int d, input logic [4:0] a, input logic [31:0] v);
    dwe[d] = 1'b1; dwa[d] = a; dwd[d] = v;
    step();
    dwe[d] = 1'b0;
  endtask

  task automatic peek(input int d, input logic [4:0] a, output logic [31:0] v);
    dra[d] = a; #1; v = drd[d];
  endtask

  // Offer one instruction for a single edge; returns just after the accept edge.
  task automatic send(input int d, input logic [31:0] w);
    int n = 0;
    while (!rdy[d] && n < 20) begin step(); n++; end
    if (n >= 20) chk(d, "ready_timeout", 32'd0, 32'd1);
    iv[d] = 1'b1; ins[d] = w;
    step();
    iv[d] = 1'b0;
  endtask

  // Cycles from accept to done (-1 if none) and to first err; ends after WRITE closes.
  task automatic wait_done(input int d, output int lat, output int errc);
    lat = -1; errc = -1;
    for (int c = 0; c < 12; c++) begin
      if (er[d] && errc < 0) errc = c;
      if (dn[d]) begin lat = c; step(); return; end
      step();
    end
  endtask

  localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;

  initial begin
    int lat, errc, hold, ndone;
    logic [31:0] v;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ins[d] = 32'd0; dwe[d] = 1'b0; dwa[d] = 5'd0; dwd[d] = 32'd0; dra[d] = 5'd0;
    end
    #1 rst = 1'b1;
    #1 cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk(0, "reset_ready", 32'(rdy[0]), 32'd1);
    chk(1, "reset_add_y", ay[1], 32'd0);

    // 1: W=0 add
    dbg_load(0, 5'd1, 32'd5);
    dbg_load(0, 5'd2, 32'd7);
    send(0, mk(6'd0, F_ADD, 5'd1, 5'd2, 5'd3));
    wait_done(0, lat, errc);
    chk(0, "s1_latency", 32'(lat), 32'd2);
    chk(0, "s1_no_err", 32'(errc), 32'hFFFF_FFFF);
    peek(0, 5'd3, v);
    chk(0, "s1_R3", v, 32'd12);
    chk(0, "s1_model_R3", m_reg[0][3], 32'd12);

    // 2: W=3 sub, operand hold
    dbg_load(1, 5'd1, 32'd10);
    dbg_load(1, 5'd2, 32'd3);
    send(1, mk(6'd0, F_SUB, 5'd1, 5'd2, 5'd4));
    hold = 0; lat = -1;
    for (int c = 0; c < 12 && lat < 0; c++) begin
      if (dn[1]) lat = c;
      else if (c >= 1 && ay[1] == 32'hFFFF_FFFD) hold++;
      step();
    end
    chk(1, "s2_latency", 32'(lat), 32'd5);
    chk(1, "s2_y_hold", 32'(hold), 32'd4);
    peek(1, 5'd4, v);
    chk(1, "s2_R4", v, 32'd7);

    // 3: wrap-around
    dbg_load(0, 5'd5, 32'h55);
    dbg_load(0, 5'd1, 32'hFFFF_FFFF);
    dbg_load(0, 5'd2, 32'd1);
    send(0, mk(6'd0, F_ADDU, 5'd1, 5'd2, 5'd5));
    wait_done(0, lat, errc);
    peek(0, 5'd5, v);
    chk(0, "s3_R5", v, 32'd0);
    dbg_load(0, 5'd1, 32'd0);
    send(0, mk(6'd0, F_SUBU, 5'd1, 5'd2, 5'd6));
    wait_done(0, lat, errc);
    peek(0, 5'd6, v);
    chk(0, "s3_R6", v, 32'hFFFF_FFFF);

    // 4: illegal op and funct
    for (int k = 0; k < 2; k++) begin
      send(1, (k == 0) ? mk(6'b001000, F_ADD, 5'd1, 5'd2, 5'd4) : mk(6'd0, 6'b100100, 5'd1, 5'd2, 5'd4));
      chk(1, "s4_err", 32'(er[1]), 32'd1);
      chk(1, "s4_not_ready", 32'(rdy[1]), 32'd0);
      step();
      chk(1, "s4_err_gone", 32'(er[1]), 32'd0);
      chk(1, "s4_ready_back", 32'(rdy[1]), 32'd1);
      wait_done(1, lat, errc);
      chk(1, "s4_no_done", 32'(lat), 32'hFFFF_FFFF);
      peek(1, 5'd4, v);
      chk(1, "s4_R4_kept", v, 32'd7);
    end

    // 5: rd=0 and back-to-back accumulate
    send(0, mk(6'd0, F_ADD, 5'd1, 5'd2, 5'd0));
    wait_done(0, lat, errc);
    chk(0, "s5_rd0_done", 32'(lat), 32'd2);
    peek(0, 5'd0, v);
    chk(0, "s5_R0", v, 32'd0);
    dbg_load(0, 5'd1, 32'd3);
    iv[0] = 1'b1; ins[0] = mk(6'd0, F_ADD, 5'd1, 5'd1, 5'd1);
    ndone = 0;
    for (int c = 0; c < 5; c++) begin step(); if (dn[0]) ndone++; end
    iv[0] = 1'b0;
    for (int c = 0; c < 8; c++) begin step(); if (dn[0]) ndone++; end
    chk(0, "s5_two_dones", 32'(ndone), 32'd2);
    peek(0, 5'd1, v);
    chk(0, "s5_R1", v, 32'd12);

    // 6: reset during EXEC
    dbg_load(1, 5'd1, 32'd1);
    dbg_load(1, 5'd2, 32'd2);
    send(1, mk(6'd0, F_ADD, 5'd1, 5'd2, 5'd7));
    step();
    rst = 1'b1;
    #1;
    chk(1, "s6_ready", 32'(rdy[1]), 32'd1);
    chk(1, "s6_done", 32'(dn[1]), 32'd0);
    for (int a = 0; a < 32; a++) begin
      peek(1, 5'(a), v);
      chk(1, "s6_cleared", v, 32'd0);
    end
    step(); step();
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin step(); if (dn[1]) ndone++; end
    chk(1, "s6_no_late_done", 32'(ndone), 32'd0);
    peek(1, 5'd7, v);
    chk(1, "s6_R7", v, 32'd0);

    // Random traffic, checked each cycle by the compare process
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        logic [5:0] op, fn;
        dwe[d] = ($urandom_range(0, 3) == 0);
        dwa[d] = 5'($urandom_range(0, 31));
        dwd[d] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        dra[d] = 5'($urandom_range(0, 31));
        iv[d]  = ($urandom_range(0, 2) == 0);
        op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
        fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : (6'h20 + 6'($urandom_range(0, 3)));
        ins[d] = {op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), fn};
      end
      step();
    end
    for (int d = 0; d < 2; d++) begin iv[d] = 1'b0; dwe[d] = 1'b0; end
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
